shift_exec_stage: RTL and testbench

- Execute-stage wrapper for the barrel shifter in the MIPS32 datapath.
- Decodes R-type shift instructions (SLL/SRL/SRA/SLLV/SRLV/SRAV) into the shifter's Data/SRO/SA controls and registers them in stage S1.
- Feeds the combinational Shifter and captures its Result, with the destination register, in stage S2 for writeback.
- Two-deep valid/ready pipeline with stall and flush.

---
 rtl/mips_shift_pkg.sv | 33 +++
 rtl/shift_exec_stage_shifter.sv | 30 +++
 rtl/shift_exec_stage.sv | 156 +++++++++++++++
 tb/tb_shift_exec_stage.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_shift_pkg.sv
// -----------------------------------------------------------------------------
// mips_shift_pkg
// Shared definitions for the MIPS32 execute-stage barrel shifter:
//   - sro_e       : shifter operation select (SLL / SRL / SRA)
//   - FN_*        : R-type funct codes of the six shift instructions
//   - s1_entry_t  : operand/control bundle held in pipeline stage S1
// -----------------------------------------------------------------------------
package mips_shift_pkg;

    // Shift-operation select driven into the shifter. Code 2'b11 is never generated.
    typedef enum logic [1:0] {
        SRO_SLL = 2'b00,
        SRO_SRL = 2'b01,
        SRO_SRA = 2'b10
    } sro_e;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;

    // Decoded instruction as stored in S1. The destination register lives
    // outside the struct because its width is a parameter of the stage.
    typedef struct packed {
        logic [31:0] data;     // RtVal, the value to shift
        sro_e        sro;      // operation select
        logic [4:0]  sa;       // shift amount, always 0..31
        logic        illegal;  // funct was not a shift
    } s1_entry_t;

endpackage

// File: rtl/shift_exec_stage_shifter.sv
// -----------------------------------------------------------------------------
// shift_exec_stage_shifter
// Combinational 32-bit barrel shifter.
// Ports:
//   data_i    [31:0]  value to shift
//   sro_i     sro_e   operation: SLL, SRL or SRA (sign-replicating)
//   sa_i      [4:0]   shift amount 0..31
//   result_o  [31:0]  shifted value
// -----------------------------------------------------------------------------
module shift_exec_stage_shifter
    import mips_shift_pkg::*;
(
    input  logic [31:0] data_i,
    input  sro_e        sro_i,
    input  logic [4:0]  sa_i,
    output logic [31:0] result_o
);

    always_comb begin
        // NOTE: every always_comb output gets a value on every path (here the
        // default arm) so synthesis never infers a latch.
        case (sro_i)
            SRO_SLL: result_o = data_i << sa_i;
            SRO_SRL: result_o = data_i >> sa_i;
            SRO_SRA: result_o = $unsigned($signed(data_i) >>> sa_i);
            default: result_o = data_i;
        endcase
    end

endmodule

// File: rtl/shift_exec_stage.sv
// -----------------------------------------------------------------------------
// shift_exec_stage
// Execute-stage wrapper around the barrel shifter. R-type shift instructions
// are decoded into {data, sro, sa} and registered in S1; S1 drives the
// combinational shifter whose result is captured with the destination
// register in S2. Two-deep valid/ready pipeline with stall and flush.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   Flush               kills S1 and S2 contents next cycle
//   InValid / InReady   upstream handshake
//   Funct, Shamt        instruction fields
//   RtVal, RsVal        value to shift / variable shift source (bits [4:0])
//   RdIdx               destination register
//   OutValid / OutReady writeback handshake
//   Result, OutRd       shifted value and its destination register
//   Illegal             S2 entry came from a non-shift funct
// -----------------------------------------------------------------------------
module shift_exec_stage
    import mips_shift_pkg::*;
#(
    parameter int RD_W         = 5,
    parameter int ILLEGAL_PASS = 1  // 1: carry illegal ops with Illegal=1, 0: drop at S1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Flush,
    input  logic            InValid,
    output logic            InReady,
    input  logic [5:0]      Funct,
    input  logic [4:0]      Shamt,
    input  logic [31:0]     RtVal,
    input  logic [31:0]     RsVal,
    input  logic [RD_W-1:0] RdIdx,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [31:0]     Result,
    output logic [RD_W-1:0] OutRd,
    output logic            Illegal
);

    function automatic s1_entry_t decode(input logic [5:0]  funct,
                                         input logic [4:0]  shamt,
                                         input logic [4:0]  rs_sa,
                                         input logic [31:0] rt);
        s1_entry_t e;
        e.data    = rt;
        e.sro     = SRO_SLL;
        e.sa      = 5'd0;
        e.illegal = 1'b0;
        case (funct)
            FN_SLL:  e.sa = shamt;
            FN_SRL:  begin e.sro = SRO_SRL; e.sa = shamt; end
            FN_SRA:  begin e.sro = SRO_SRA; e.sa = shamt; end
            FN_SLLV: e.sa = rs_sa;
            FN_SRLV: begin e.sro = SRO_SRL; e.sa = rs_sa; end
            FN_SRAV: begin e.sro = SRO_SRA; e.sa = rs_sa; end
            // Unknown funct degenerates to SLL 0, so Result equals RtVal.
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    // Only the low five bits of RsVal form a shift amount.
    logic unused_rs_hi;
    assign unused_rs_hi = ^RsVal[31:5];

    logic            s1_valid_q, s1_valid_d;
    s1_entry_t       s1_q, s1_d;
    logic [RD_W-1:0] s1_rd_q, s1_rd_d;
    logic            s2_valid_q, s2_valid_d;
    logic [31:0]     s2_result_q, s2_result_d;
    logic [RD_W-1:0] s2_rd_q, s2_rd_d;
    logic            s2_illegal_q, s2_illegal_d;

    logic            advance1, advance2;
    logic            load_s1;
    s1_entry_t       in_entry;
    logic [31:0]     shift_result;

    assign advance2 = !s2_valid_q | OutReady;
    assign advance1 = !s1_valid_q | advance2;
    assign in_entry = decode(Funct, Shamt, RsVal[4:0], RtVal);
    // Illegal ops are still accepted when dropped, so InReady never depends on Funct.
    assign load_s1  = InValid & advance1 & ((ILLEGAL_PASS != 0) | !in_entry.illegal);

    shift_exec_stage_shifter u_shifter (
        .data_i   (s1_q.data),
        .sro_i    (s1_q.sro),
        .sa_i     (s1_q.sa),
        .result_o (shift_result)
    );

    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_d         = s1_q;
        s1_rd_d      = s1_rd_q;
        s2_valid_d   = s2_valid_q;
        s2_result_d  = s2_result_q;
        s2_rd_d      = s2_rd_q;
        s2_illegal_d = s2_illegal_q;

        if (Flush) begin
            // Flush wins over push and pop; S2 data holds so outputs stay stable.
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end else begin
            if (advance2) begin
                s2_valid_d = s1_valid_q;
                // Bubbles do not disturb Result/OutRd/Illegal.
                if (s1_valid_q) begin
                    s2_result_d  = shift_result;
                    s2_rd_d      = s1_rd_q;
                    s2_illegal_d = s1_q.illegal;
                end
            end
            if (advance1) begin
                s1_valid_d = load_s1;
                if (load_s1) begin
                    s1_d    = in_entry;
                    s1_rd_d = RdIdx;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data registers are reset along with the valid bits
            // because Result/OutRd/Illegal must read 0 after reset.
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            s1_rd_q      <= '0;
            s2_valid_q   <= 1'b0;
            s2_result_q  <= '0;
            s2_rd_q      <= '0;
            s2_illegal_q <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_q         <= s1_d;
            s1_rd_q      <= s1_rd_d;
            s2_valid_q   <= s2_valid_d;
            s2_result_q  <= s2_result_d;
            s2_rd_q      <= s2_rd_d;
            s2_illegal_q <= s2_illegal_d;
        end
    end

    assign InReady  = advance1;
    assign OutValid = s2_valid_q;
    assign Result   = s2_result_q;
    assign OutRd    = s2_rd_q;
    assign Illegal  = s2_illegal_q;

endmodule

// File: tb/tb_shift_exec_stage.sv
// -----------------------------------------------------------------------------
// tb_shift_exec_stage
// Directed self-checking bench for shift_exec_stage (ILLEGAL_PASS=1):
// a table of single-instruction vectors with hand-computed results, plus
// hand-written sequences for backpressure, flush and mid-stream reset.
// -----------------------------------------------------------------------------
module tb_shift_exec_stage;

    localparam int RD_W = 5;

    logic            clk = 1'b0;
    logic            reset;
    logic            Flush;
    logic            InValid;
    logic            InReady;
    logic [5:0]      Funct;
    logic [4:0]      Shamt;
    logic [31:0]     RtVal;
    logic [31:0]     RsVal;
    logic [RD_W-1:0] RdIdx;
    logic            OutValid;
    logic            OutReady;
    logic [31:0]     Result;
    logic [RD_W-1:0] OutRd;
    logic            Illegal;

    int checks = 0;
    int errors = 0;

    shift_exec_stage #(.RD_W(RD_W), .ILLEGAL_PASS(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .Flush    (Flush),
        .InValid  (InValid),
        .InReady  (InReady),
        .Funct    (Funct),
        .Shamt    (Shamt),
        .RtVal    (RtVal),
        .RsVal    (RsVal),
        .RdIdx    (RdIdx),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .Result   (Result),
        .OutRd    (OutRd),
        .Illegal  (Illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; all sampling happens here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] f, input logic [4:0] sh,
                         input logic [31:0] rt, input logic [31:0] rs, input logic [RD_W-1:0] rd);
        InValid = v;
        Funct   = f;
        Shamt   = sh;
        RtVal   = rt;
        RsVal   = rs;
        RdIdx   = rd;
    endtask

    typedef struct {
        string           name;
        logic [5:0]      funct;
        logic [4:0]      shamt;
        logic [31:0]     rt;
        logic [31:0]     rs;
        logic [RD_W-1:0] rd;
        logic [31:0]     exp_res;
        logic            exp_ill;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int              idx;
        int              got;
        int              seen;
        logic            accept;
        logic [31:0]     exp_q[$];
        logic [RD_W-1:0] exp_rd_q[$];

        vecs[0] = '{"sll31",    6'b000000, 5'd31, 32'h0000_0001, 32'h0,         5'd1,  32'h8000_0000, 1'b0};
        vecs[1] = '{"srl4",     6'b000010, 5'd4,  32'h8000_00F0, 32'h0,         5'd2,  32'h0800_000F, 1'b0};
        vecs[2] = '{"sra4",     6'b000011, 5'd4,  32'h8000_00F0, 32'h0,         5'd3,  32'hF800_000F, 1'b0};
        vecs[3] = '{"srav_msk", 6'b000111, 5'd9,  32'hFFFF_FF00, 32'hFFFF_FFE3, 5'd4,  32'hFFFF_FFE0, 1'b0};
        vecs[4] = '{"sllv_32",  6'b000100, 5'd5,  32'h1234_5678, 32'h0000_0020, 5'd5,  32'h1234_5678, 1'b0};
        vecs[5] = '{"sllv_33",  6'b000100, 5'd0,  32'h0000_0003, 32'h0000_0021, 5'd6,  32'h0000_0006, 1'b0};
        vecs[6] = '{"srlv31",   6'b000110, 5'd0,  32'h8000_0000, 32'h0000_001F, 5'd7,  32'h0000_0001, 1'b0};
        vecs[7] = '{"sll0",     6'b000000, 5'd0,  32'hDEAD_BEEF, 32'h0,         5'd8,  32'hDEAD_BEEF, 1'b0};
        vecs[8] = '{"sra_pos",  6'b000011, 5'd31, 32'h7FFF_FFFF, 32'h0,         5'd9,  32'h0000_0000, 1'b0};
        vecs[9] = '{"illegal",  6'b100000, 5'd7,  32'hCAFE_F00D, 32'h0000_0004, 5'd10, 32'hCAFE_F00D, 1'b1};

        // ---------------- reset state ----------------
        reset    = 1'b1;
        Flush    = 1'b0;
        OutReady = 1'b1;
        drive(1'b0, 6'd0, 5'd0, 32'h0, 32'h0, '0);
        step();
        step();
        reset = 1'b0;
        #1;
        check("rst_outvalid", {31'b0, OutValid}, 32'd0);
        check("rst_result",   Result,            32'd0);
        check("rst_outrd",    {27'b0, OutRd},    32'd0);
        check("rst_illegal",  {31'b0, Illegal},  32'd0);
        check("rst_inready",  {31'b0, InReady},  32'd1);

        // ---------------- table vectors, OutReady=1 ----------------
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].funct, vecs[i].shamt, vecs[i].rt, vecs[i].rs, vecs[i].rd);
            #1;
            check({vecs[i].name, "_inready"}, {31'b0, InReady}, 32'd1);
            step();                                   // accept edge: S1 loads
            check({vecs[i].name, "_lat1"}, {31'b0, OutValid}, 32'd0);
            InValid = 1'b0;
            step();                                   // S2 loads
            check({vecs[i].name, "_lat2"},    {31'b0, OutValid}, 32'd1);
            check({vecs[i].name, "_result"},  Result,            vecs[i].exp_res);
            check({vecs[i].name, "_rd"},      {27'b0, OutRd},    {27'b0, vecs[i].rd});
            check({vecs[i].name, "_illegal"}, {31'b0, Illegal},  {31'b0, vecs[i].exp_ill});
        end
        step();
        check("drain_outvalid", {31'b0, OutValid}, 32'd0);

        // ---------------- backpressure: 4 SLL-by-1 ops ----------------
        OutReady = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 6'b000000, 5'd1, idx + 1, 32'h0, RD_W'(idx + 1));
            #1;
            accept = InValid && InReady;
            step();
            if (accept) idx++;
        end
        check("bp_accepts",  idx, 32'd2);
        check("bp_inready",  {31'b0, InReady},  32'd0);
        check("bp_outvalid", {31'b0, OutValid}, 32'd1);
        check("bp_held_res", Result,            32'd2);
        check("bp_held_rd",  {27'b0, OutRd},    32'd1);

        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(32'(k + 1) << 1);
            exp_rd_q.push_back(RD_W'(k + 1));
        end
        OutReady = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            if (idx < 4) drive(1'b1, 6'b000000, 5'd1, idx + 1, 32'h0, RD_W'(idx + 1));
            else         InValid = 1'b0;
            #1;
            accept = InValid && InReady;
            if (OutValid) begin
                check("bp_order_res", Result,         exp_q.pop_front());
                check("bp_order_rd",  {27'b0, OutRd}, {27'b0, exp_rd_q.pop_front()});
                got++;
            end
            step();
            if (accept) idx++;
        end
        check("bp_count", got, 32'd4);
        InValid = 1'b0;
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (OutValid) seen++;
            step();
        end
        check("bp_no_dup", seen, 32'd0);

        // ---------------- flush with both stages full plus new input ----------------
        OutReady = 1'b0;
        drive(1'b1, 6'b000000, 5'd0, 32'h0000_0011, 32'h0, 5'd7);
        step();
        drive(1'b1, 6'b000000, 5'd0, 32'h0000_0022, 32'h0, 5'd8);
        step();
        check("fl_full_inready", {31'b0, InReady}, 32'd0);
        check("fl_pre_result",   Result,           32'h0000_0011);
        drive(1'b1, 6'b000000, 5'd0, 32'h0000_0033, 32'h0, 5'd9);
        Flush = 1'b1;
        step();
        Flush   = 1'b0;
        InValid = 1'b0;
        check("fl_outvalid", {31'b0, OutValid}, 32'd0);
        check("fl_result",   Result,            32'h0000_0011);
        check("fl_inready",  {31'b0, InReady},  32'd1);
        OutReady = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (OutValid) seen++;
            step();
        end
        check("fl_no_result", seen, 32'd0);

        // ---------------- reset mid-stream ----------------
        drive(1'b1, 6'b000010, 5'd4, 32'h0000_00F0, 32'h0, 5'd9);
        step();
        drive(1'b1, 6'b000000, 5'd1, 32'h0000_0005, 32'h0, 5'd3);
        step();
        check("mr_pre_valid",  {31'b0, OutValid}, 32'd1);
        check("mr_pre_result", Result,            32'h0000_000F);
        reset = 1'b1;
        step();
        reset   = 1'b0;
        InValid = 1'b0;
        check("mr_outvalid", {31'b0, OutValid}, 32'd0);
        check("mr_result",   Result,            32'd0);
        check("mr_outrd",    {27'b0, OutRd},    32'd0);
        check("mr_illegal",  {31'b0, Illegal},  32'd0);
        check("mr_inready",  {31'b0, InReady},  32'd1);
        step();
        check("mr_s1_killed", {31'b0, OutValid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
